// File: rtl/lv_pwm_dt_pkg.sv
// Shared types and constants for the LV-side PWM dead-time stage.
package lv_pkg;

  localparam int unsigned LV_PWM_DT_W        = 8;
  localparam int unsigned LV_PWM_DGL_W       = 4;
  localparam int unsigned LV_PWM_SYNC_DEPTH  = 2;

  typedef enum logic [2:0] {
    LV_OFF   = 3'd0,
    LV_DT_H  = 3'd1,
    LV_H_ON  = 3'd2,
    LV_DT_L  = 3'd3,
    LV_L_ON  = 3'd4,
    LV_FAULT = 3'd5
  } lv_pwm_st_e;

endpackage

// File: rtl/lv_pwm_dt_dgl_filter.sv
// Deglitch filter: output follows input only after it has differed for dgl_cyc+1 cycles.
module lv_dgl_filter
  import lv_pkg::*;
#(
  parameter int unsigned DGL_W = LV_PWM_DGL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [DGL_W-1:0] dgl_cyc,
  output logic             dout
);

  logic [DGL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == dgl_cyc) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lv_pwm_dt.sv
// PWM synchroniser, optional deglitch and dead-time FSM with shoot-through fault latch.
// Define LV_PWM_DGL_EN to insert an lv_dgl_filter on each synchronised input.
module lv_pwm_dt
  import lv_pkg::*;
#(
  parameter int unsigned DT_W  = LV_PWM_DT_W,
  parameter int unsigned DGL_W = LV_PWM_DGL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_en,
  input  logic             pwm_h_i,
  input  logic             pwm_l_i,
  input  logic [DT_W-1:0]  dt_cyc,
  input  logic [DGL_W-1:0] dgl_cyc,
  input  logic             fault_clr,
  output logic             gate_h_o,
  output logic             gate_l_o,
  output logic             st_fault_o,
  output logic [2:0]       st_state_o
);

  logic [LV_PWM_SYNC_DEPTH-1:0] sync_h, sync_l;
  logic                         s_h, s_l, f_h, f_l;
  logic [DT_W-1:0]              dt_cnt;
  lv_pwm_st_e                   state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_h <= '0;
      sync_l <= '0;
    end else begin
      sync_h <= {sync_h[LV_PWM_SYNC_DEPTH-2:0], pwm_h_i};
      sync_l <= {sync_l[LV_PWM_SYNC_DEPTH-2:0], pwm_l_i};
    end
  end

  assign s_h = sync_h[LV_PWM_SYNC_DEPTH-1];
  assign s_l = sync_l[LV_PWM_SYNC_DEPTH-1];

`ifdef LV_PWM_DGL_EN
  lv_dgl_filter #(.DGL_W(DGL_W)) u_dgl_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (s_h),
    .dgl_cyc (dgl_cyc),
    .dout    (f_h)
  );

  lv_dgl_filter #(.DGL_W(DGL_W)) u_dgl_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (s_l),
    .dgl_cyc (dgl_cyc),
    .dout    (f_l)
  );
`else
  logic unused_dgl;
  assign unused_dgl = ^dgl_cyc;
  assign f_h = s_h;
  assign f_l = s_l;
`endif

  // Gates are set in the same branch that selects the next state, so they
  // are registered decodes of it; a latched fault survives an enable drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LV_OFF;
      dt_cnt     <= '0;
      gate_h_o   <= 1'b0;
      gate_l_o   <= 1'b0;
      st_fault_o <= 1'b0;
    end else begin
      gate_h_o <= 1'b0;
      gate_l_o <= 1'b0;
      if (pwm_en && f_h && f_l && state != LV_FAULT) begin
        state      <= LV_FAULT;
        st_fault_o <= 1'b1;
        dt_cnt     <= '0;
      end else if (!pwm_en && state != LV_FAULT) begin
        state  <= LV_OFF;
        dt_cnt <= '0;
      end else begin
        case (state)
          LV_OFF: begin
            if (f_h) begin
              state  <= LV_DT_H;
              dt_cnt <= dt_cyc;
            end else if (f_l) begin
              state  <= LV_DT_L;
              dt_cnt <= dt_cyc;
            end
          end
          LV_DT_H: begin
            if (!f_h) begin
              state  <= LV_OFF;
              dt_cnt <= '0;
            end else if (dt_cnt == '0) begin
              state    <= LV_H_ON;
              gate_h_o <= 1'b1;
            end else begin
              dt_cnt <= dt_cnt - 1'b1;
            end
          end
          LV_H_ON: begin
            if (!f_h && f_l) begin
              state  <= LV_DT_L;
              dt_cnt <= dt_cyc;
            end else if (!f_h) begin
              state <= LV_OFF;
            end else begin
              gate_h_o <= 1'b1;
            end
          end
          LV_DT_L: begin
            if (!f_l) begin
              state  <= LV_OFF;
              dt_cnt <= '0;
            end else if (dt_cnt == '0) begin
              state    <= LV_L_ON;
              gate_l_o <= 1'b1;
            end else begin
              dt_cnt <= dt_cnt - 1'b1;
            end
          end
          LV_L_ON: begin
            if (!f_l && f_h) begin
              state  <= LV_DT_H;
              dt_cnt <= dt_cyc;
            end else if (!f_l) begin
              state <= LV_OFF;
            end else begin
              gate_l_o <= 1'b1;
            end
          end
          LV_FAULT: begin
            if (fault_clr && !f_h && !f_l) begin
              state      <= LV_OFF;
              st_fault_o <= 1'b0;
            end
          end
          default: begin
            state  <= LV_OFF;
            dt_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign st_state_o = state;

endmodule
